// File: rtl/iter_divider.sv
// Radix-2 restoring divider for the ALU stage's UDIV/SDIV path: one quotient bit per
// cycle on operand magnitudes, with a final sign fix-up and a one-cycle valid_out pulse.
module iter_divider #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             valid_q, valid_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, diff;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  // Partial remainder is always below the divisor, so its top bit is never needed
  // once the shifted-in value has been compared.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          signed_d = is_signed;
          q_neg_d  = dvd_neg ^ dvs_neg;
          r_neg_d  = dvd_neg;
          dvd_d    = dvd_mag;
          dvs_d    = dvs_mag;
          rem_d    = '0;
          cnt_d    = CNT_W'(WIDTH - 1);
          if (divisor == '0) begin
            // Divide-by-zero results load now; the pass through FIXUP only delays the
            // valid pulse by one cycle without touching the outputs again.
            dz_d        = 1'b1;
            quotient_d  = '0;
            remainder_d = dividend;
            state_d     = S_FIXUP;
          end else begin
            dz_d    = 1'b0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIXUP;
      end

      S_FIXUP: begin
        if (!dz_q) begin
          quotient_d  = (signed_q && q_neg_q) ? -dvd_q : dvd_q;
          remainder_d = (signed_q && r_neg_q) ? -rem_q : rem_q;
        end
        valid_d = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      signed_q    <= signed_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign valid_out = valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_iter_divider.sv
// Directed and randomized checks of iter_divider: results, latency, pulse width,
// reset abort and the stage-FSM handshake.
module tb_iter_divider;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         valid_out;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  iter_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .valid_out (valid_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    logic [W-1:0] ma, mb;
    if (b == '0) begin
      q = '0;
      r = a;
      lat = 1;
    end else begin
      ma = (s && a[W-1]) ? -a : a;
      mb = (s && b[W-1]) ? -b : b;
      q = ma / mb;
      r = ma % mb;
      if (s && (a[W-1] ^ b[W-1])) q = -q;
      if (s && a[W-1]) r = -r;
      lat = W + 1;
    end
  endfunction

  // Entered and left during the low clock phase; applies one request and checks the result.
  task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int elat, input bit hold, output int e0);
    bit seen;
    int lat;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    @(negedge clk);
    check({name, "_busy_e0"}, W'(busy), W'(1));
    check({name, "_no_early_valid"}, W'(valid_out), W'(0));
    valid_in  = hold;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
    is_signed = 1'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_out) begin
        seen = 1'b1;
        lat  = k;
      end else if (hold) begin
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        is_signed = 1'($urandom);
      end
    end
    valid_in = 1'b0;
    if (!seen) begin
      check({name, "_timeout"}, W'(0), W'(1));
    end else begin
      check({name, "_latency"}, W'(lat), W'(elat));
      check({name, "_quotient"}, quotient, eq);
      check({name, "_remainder"}, remainder, er);
      @(posedge clk);
      @(negedge clk);
      check({name, "_pulse_width"}, W'(valid_out), W'(0));
      check({name, "_busy_after"}, W'(busy), W'(0));
      check({name, "_q_held"}, quotient, eq);
      check({name, "_r_held"}, remainder, er);
    end
  endtask

  vec_t vecs[12];

  initial begin
    int           e0a, e0b, e0c, mlat;
    bit           seen_v;
    logic [W-1:0] ra, rb, mq, mr;
    logic         rs;

    vecs[0]  = '{"u100_7",     64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 65};
    vecs[1]  = '{"s_m100_7",   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{"s_100_m7",   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 65};
    vecs[3]  = '{"s_m100_m7",  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
                 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[4]  = '{"u_dz",       64'h1234, 64'd0, 1'b0, 64'd0, 64'h1234, 1};
    vecs[5]  = '{"s_dz",       64'h1234, 64'd0, 1'b1, 64'd0, 64'h1234, 1};
    vecs[6]  = '{"s_dz_neg",   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
                 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{"s_min_m1",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                 64'h8000_0000_0000_0000, 64'd0, 65};
    vecs[8]  = '{"u_max_1",    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
    vecs[9]  = '{"u7_100",     64'd7, 64'd100, 1'b0, 64'd0, 64'd7, 65};
    vecs[10] = '{"s_min_1",    64'h8000_0000_0000_0000, 64'd1, 1'b1,
                 64'h8000_0000_0000_0000, 64'd0, 65};
    vecs[11] = '{"u_max_max",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                 64'd1, 64'd0, 65};

    reset     = 1'b0;
    valid_in  = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_valid", W'(valid_out), W'(0));
    check("reset_busy", W'(busy), W'(0));
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", W'(busy), W'(0));

    foreach (vecs[i])
      run_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r,
              vecs[i].lat, 1'b0, e0a);

    // Abort mid-CALC: reset sampled at E0+20 clears everything and no pulse follows.
    is_signed = 1'b0;
    dividend  = 64'd1000;
    divisor   = 64'd3;
    valid_in  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_valid", W'(valid_out), W'(0));
    check("abort_busy", W'(busy), W'(0));
    reset  = 1'b1;
    seen_v = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (valid_out) seen_v = 1'b1;
    end
    check("abort_no_valid", W'(seen_v), W'(0));
    run_div("after_abort_50_5", 64'd50, 64'd5, 1'b0, 64'd10, 64'd0, 65, 1'b0, e0a);

    // valid_in held through CALC with changing operands, dropped in DONE, then 81/9 next cycle.
    run_div("hold_1000_7", 64'd1000, 64'd7, 1'b0, 64'd142, 64'd6, 65, 1'b1, e0a);
    run_div("b2b_81_9", 64'd81, 64'd9, 1'b0, 64'd9, 64'd0, 65, 1'b0, e0b);
    check("b2b_accept_gap", W'(e0b - e0a), W'(67));
    run_div("b2b_dz", 64'h55, 64'd0, 1'b0, 64'd0, 64'h55, 1, 1'b0, e0c);
    check("dz_accept_gap", W'(e0c - e0b), W'(67));

    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rs = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rb = {$urandom, $urandom};
        1: rb = 64'($urandom_range(1, 1000));
        2: rb = -64'($urandom_range(1, 1000));
        default: rb = {32'd0, $urandom};
      endcase
      model(ra, rb, rs, mq, mr, mlat);
      run_div($sformatf("rand%0d", i), ra, rb, rs, mq, mr, mlat, 1'b0, e0a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
